sm_sdram_bist: RTL
==================

// Module: sm_sdram_bist
// PURPOSE
//  Built-in self-test sequencer sitting directly upstream of sm_sdram_controller, driving its cs/we/a/wd request port.
//  On start it writes a deterministic pattern to every word address, then reads each word back and compares it.
//  It reports busy/done, pass/fail, a saturating error count and the first failing address for board LEDs.
// PARAMETERS
//  ADDR_W   6             controller word-address width; test covers 0 .. 2**ADDR_W-1
//  DATA_W   32            controller data width
//  SEED     32'h87654321  pattern base
//  STEP     32'h9E3779B9  pattern address multiplier
//  TIMEOUT  1023          max cycles waiting for ready/re before abort (10-bit counter)
// PORTS
//  clkIn           in   1       single clock, same as controller clock
//  rst_n           in   1       asynchronous active-low reset
//  start           in   1       start test; sampled only in IDLE/DONE
//  ready           in   1       controller idle; request accepted when cs&ready
//  re              in   1       controller read-data-valid pulse; rd valid same cycle
//  rd              in   DATA_W  controller read data
//  cs              out  1       request strobe to controller
//  we              out  1       1=write, 0=read
//  a               out  ADDR_W  word address
//  wd              out  DATA_W  write data
//  busy            out  1       test in progress
//  done            out  1       test finished; held until next start
//  pass_ok         out  1       valid when done: 1 = no mismatches and no timeout
//  timeout         out  1       sticky: controller did not respond within TIMEOUT
//  err_cnt         out  8       mismatches, saturates at 8'hFF
//  first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal addr/pass/timer 0.
//  pat(x) = SEED + x*STEP + pass_num, mod 2**DATA_W (pass_num=0 unless loop enabled).
//  FSM: IDLE -> WR_REQ -> WR_WAIT -> (next addr) ... -> RD_REQ -> RD_WAIT -> CHECK -> ... -> DONE.
//  IDLE/DONE: start=1 -> WR_REQ, addr=0, clear err_cnt/first_err_addr/timeout/pass_ok/done, busy=1.
//  WR_REQ: cs=1, we=1, a=addr, wd=pat(addr); on ready=1 request accepted that cycle -> WR_WAIT, cs=0 next cycle.
//  WR_WAIT: wait for ready sampled 0 then ready 1; then addr==max -> RD_REQ with addr=0, else addr+1 -> WR_REQ.
//  RD_REQ: cs=1, we=0, a=addr; on ready=1 -> RD_WAIT, cs=0.
//  RD_WAIT: on re=1 capture rd -> CHECK. Late re (after abort) ignored.
//  CHECK (1 cycle): rd!=pat(addr) -> err_cnt+1 (sat), first_err_addr=addr if err_cnt was 0;
//    addr==max -> DONE else addr+1 -> RD_REQ.
//  cs high at most until accepted; never two requests without an intervening wait state.
//  a/wd/we held stable while cs=1.
//  Timer: reset on every state entry; any REQ/WAIT state lasting TIMEOUT cycles -> timeout=1, cs=0, DONE.
//  DONE: busy=0, done=1, pass_ok=(err_cnt==0 && !timeout).
//  Address wrap: addr increments only inside range; ADDR_W-bit compare with all-ones decides last.
//  start while busy: ignored.
//  rst_n low mid-test: immediate abort to reset values; controller request drops asynchronously.
// CONFIGURATION
//  SM_BIST_LOOP_EN defined:
//    DONE with pass_ok=1 auto-restarts WR_REQ next cycle with pass_num+1 (8-bit, wraps), so pattern shifts each pass.
//    done pulses 1 cycle per pass; on fail or timeout stays in DONE.
//  Undefined: single pass, pass_num fixed 0, remain in DONE until start.
// TESTING
//  Ideal controller model (ready drops 2 cycles after accept, re 3 cycles after read accept), start pulse
//    -> 64 writes then 64 reads, done=1, pass_ok=1, err_cnt=0.
//  Model corrupts rd at addr 3 and 10 -> err_cnt=2, first_err_addr=3, pass_ok=0.
//  Model never asserts re on read of addr 0 -> after 1023 cycles timeout=1, cs=0, done=1, pass_ok=0.
//  Model corrupts every read -> err_cnt saturates at 8'hFF, not 8'h00.
//  Drop rst_n during RD_WAIT at addr 20 -> next cycle all outputs 0, IDLE; new start -> full clean pass.
//  Loop build, clean model -> wd at addr 0 is 32'h87654321 pass 0, 32'h87654322 pass 1; done pulses twice.

Source files
------------

// File: rtl/sm_sdram_bist_if.sv
// sm_sdram_bist_if: request/response bus between the BIST sequencer and sm_sdram_controller.
//   cs/we/a/wd : request strobe, write flag, word address, write data (master drives)
//   ready      : controller idle; a request is accepted on a cycle with cs & ready
//   re/rd      : read-data-valid pulse and read data, valid in the same cycle
interface sm_sdram_bist_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic              ready;
    logic              re;
    logic [DATA_W-1:0] rd;
    modport master (output cs, we, a, wd, input ready, re, rd);
    modport slave (input cs, we, a, wd, output ready, re, rd);
endinterface

// File: rtl/sm_sdram_bist.sv
// sm_sdram_bist: self-test sequencer that writes a pattern to every word, reads it back and reports the result.
//   clkIn          : clock shared with the controller
//   rst_n          : asynchronous active-low reset
//   start          : begin a test (honoured only when idle or done)
//   bus            : master side of sm_sdram_bist_if (cs/we/a/wd out, ready/re/rd in)
//   busy, done     : test in progress / finished (done held until the next start)
//   pass_ok        : with done, no mismatches and no timeout
//   timeout        : sticky, controller stalled for TIMEOUT cycles in a request/wait state
//   err_cnt        : mismatch count, saturating at 8'hFF
//   first_err_addr : address of the first mismatch, 0 if none
//   Build option SM_BIST_LOOP_EN: a clean pass restarts automatically with the pattern offset by one.
module sm_sdram_bist #(
    parameter int                ADDR_W  = 6,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SEED    = 32'h87654321,
    parameter logic [DATA_W-1:0] STEP    = 32'h9E3779B9,
    parameter int                TIMEOUT = 1023
) (
    input  logic                  clkIn,
    input  logic                  rst_n,
    input  logic                  start,
    sm_sdram_bist_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass_ok,
    output logic                  timeout,
    output logic [7:0]            err_cnt,
    output logic [ADDR_W-1:0]     first_err_addr
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE} state_t;
    state_t            state, nxt;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        timer;
    logic              seen_low;
    logic [DATA_W-1:0] rd_q, pat;
    logic [7:0]        pass_num;
    logic              restart, go, last, timed, abort;
`ifdef SM_BIST_LOOP_EN
    assign restart = state == DONE && pass_ok;
    // An explicit start always begins again at pass 0; only auto-restarts advance the pass.
    always_ff @(posedge clkIn or negedge rst_n)
        if (!rst_n) pass_num <= '0;
        else if (go) pass_num <= start ? 8'd0 : pass_num + 8'd1;
`else
    assign restart = 1'b0;
    assign pass_num = '0;
`endif
    assign last  = addr == '1;
    assign timed = state inside {WR_REQ, WR_WAIT, RD_REQ, RD_WAIT};
    assign go    = (state == IDLE || state == DONE) && (start || restart);
    assign pat   = SEED + DATA_W'(addr) * STEP + DATA_W'(pass_num);
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = go ? WR_REQ : state;
            WR_REQ:     nxt = bus.ready ? WR_WAIT : WR_REQ;
            // the controller must be seen busy before its ready counts as write completion
            WR_WAIT:    nxt = (seen_low && bus.ready) ? (last ? RD_REQ : WR_REQ) : WR_WAIT;
            RD_REQ:     nxt = bus.ready ? RD_WAIT : RD_REQ;
            RD_WAIT:    nxt = bus.re ? CHECK : RD_WAIT;
            CHECK:      nxt = last ? DONE : RD_REQ;
            default:    nxt = IDLE;
        endcase
        // progress on the final cycle wins over the abort
        abort = timed && nxt == state && timer == 10'(TIMEOUT - 1);
        if (abort) nxt = DONE;
    end
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            timer          <= '0;
            seen_low       <= 1'b0;
            rd_q           <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else begin
            state    <= nxt;
            timer    <= nxt != state ? 10'd0 : timer + 10'd1;
            seen_low <= state == WR_WAIT && (seen_low || !bus.ready);
            if (go) begin
                addr           <= '0;
                err_cnt        <= '0;
                first_err_addr <= '0;
                timeout        <= 1'b0;
            end
            if ((state == WR_WAIT && nxt == WR_REQ) || (state == CHECK && !last)) addr <= addr + 1'b1;
            if (state == WR_WAIT && nxt == RD_REQ) addr <= '0;
            if (state == RD_WAIT && bus.re) rd_q <= bus.rd;
            if (state == CHECK && rd_q != pat) begin
                err_cnt        <= err_cnt + 8'(err_cnt != 8'hFF);
                first_err_addr <= err_cnt == 8'd0 ? addr : first_err_addr;
            end
            if (abort) timeout <= 1'b1;
        end
    end
    // request outputs decode straight from the state so reset drops them asynchronously
    assign bus.cs  = state == WR_REQ || state == RD_REQ;
    assign bus.we  = state == WR_REQ;
    assign bus.a   = bus.cs ? addr : '0;
    assign bus.wd  = bus.we ? pat : '0;
    assign busy    = !(state == IDLE || state == DONE);
    assign done    = state == DONE;
    assign pass_ok = done && err_cnt == 8'd0 && !timeout;
endmodule
